// File: rtl/if_sp_pkg.sv
// Shared definitions for the IF scratchpad circular buffer (writer and read-side checker).
//   state_e   : writer FSM states
//   *_DEF     : default buffer geometry
//   mod_inc() : circular increment modulo n, correct for non-power-of-two n
package if_sp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned IF_ADDRESS_SIZE_DEF = 3;
  localparam int unsigned CELL_NUMS_IF_DEF    = 8;

  // Widest pointer the helper handles; callers cast in and out.
  localparam int unsigned PTR_W_MAX = 16;

  function automatic logic [PTR_W_MAX-1:0] mod_inc(input logic [PTR_W_MAX-1:0] ptr,
                                                   input logic [PTR_W_MAX-1:0] n);
    return (ptr >= n - PTR_W_MAX'(1)) ? '0 : ptr + PTR_W_MAX'(1);
  endfunction

endpackage

// File: rtl/circ_ptr.sv
// Modulo-N pointer register.
//   clk, rst : clock, async active-high reset (pointer -> 0)
//   inc_i    : advance pointer by one, wrapping N-1 -> 0
//   ptr_o    : current pointer value
module circ_ptr
  import if_sp_pkg::*;
#(
  parameter int unsigned W = 3,
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = W'(mod_inc(PTR_W_MAX'(ptr_q), PTR_W_MAX'(N)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/if_scratch_writer.sv
// Producer side of the IF scratchpad circular buffer.
//   clk, rst            : clock, async active-high reset
//   start, if_size      : begin a job with if_size elements per row (1..7)
//   in_data/valid/last  : input element stream; in_ready is the combinational accept qualifier
//   write_start         : reader's oldest live cell (back-pressure reference)
//   sp_wr_en/addr/data  : registered scratchpad write port
//   write_cnt_if        : committed write pointer, advances one cycle after the write
//   row_done            : pulse alongside the write that completes a row or carries in_last
//   done, err           : job finished (level), sticky error
module if_scratch_writer
  import if_sp_pkg::*;
#(
  parameter int unsigned IF_CELL_SIZE    = 8,
  parameter int unsigned IF_ADDRESS_SIZE = IF_ADDRESS_SIZE_DEF,
  parameter int unsigned CELL_NUMS_IF    = CELL_NUMS_IF_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 if_size,
  input  logic [IF_CELL_SIZE-1:0]    in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic [IF_ADDRESS_SIZE-1:0] write_start,
  output logic                       sp_wr_en,
  output logic [IF_ADDRESS_SIZE-1:0] sp_wr_addr,
  output logic [IF_CELL_SIZE-1:0]    sp_wr_data,
  output logic [IF_ADDRESS_SIZE-1:0] write_cnt_if,
  output logic                       row_done,
  output logic                       done,
  output logic                       err
);

  state_e state_q, state_d;

  logic [2:0]                 size_q, size_d;
  logic [2:0]                 col_q, col_d;
  logic                       err_q, err_d;
  logic                       wr_en_q, wr_en_d;
  logic [IF_ADDRESS_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [IF_CELL_SIZE-1:0]    wr_data_q, wr_data_d;
  logic                       row_done_q, row_done_d;

  logic [IF_ADDRESS_SIZE-1:0] wr_ptr;
  logic                       full_c;
  logic                       last_col_c;
  logic                       accept_c;

  // One cell stays empty so full and empty are distinguishable.
  assign full_c = IF_ADDRESS_SIZE'(mod_inc(PTR_W_MAX'(wr_ptr), PTR_W_MAX'(CELL_NUMS_IF)))
                  == write_start;
  assign last_col_c = (col_q == size_q - 3'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start && (if_size != 3'd0)) state_d = RUN;
      RUN:        if (accept_c && in_last)        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    in_ready   = 1'b0;
    accept_c   = 1'b0;
    size_d     = size_q;
    col_d      = col_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    row_done_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (if_size == 3'd0) begin
            err_d = 1'b1;
          end else begin
            size_d = if_size;
            col_d  = 3'd0;
            // A new job after DONE starts with a clean error flag.
            if (state_q == DONE) err_d = 1'b0;
          end
        end
      end
      RUN: begin
        in_ready = !full_c;
        accept_c = in_valid && !full_c;
        if (accept_c) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = wr_ptr;
          wr_data_d  = in_data;
          row_done_d = last_col_c || in_last;
          col_d      = last_col_c ? 3'd0 : col_q + 3'd1;
          if (in_last && !last_col_c) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q     <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      row_done_q <= 1'b0;
    end else begin
      size_q     <= size_d;
      col_q      <= col_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      row_done_q <= row_done_d;
    end
  end

  // Next cell to write; advances on accept.
  circ_ptr #(.W(IF_ADDRESS_SIZE), .N(CELL_NUMS_IF)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (accept_c),
    .ptr_o (wr_ptr)
  );

  // Committed pointer trails by one cycle, so the reader never counts an unwritten cell.
  circ_ptr #(.W(IF_ADDRESS_SIZE), .N(CELL_NUMS_IF)) u_commit_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_en_q),
    .ptr_o (write_cnt_if)
  );

  assign sp_wr_en   = wr_en_q;
  assign sp_wr_addr = wr_addr_q;
  assign sp_wr_data = wr_data_q;
  assign row_done   = row_done_q;
  assign done       = (state_q == DONE);
  assign err        = err_q;

endmodule

// File: doc/if_scratch_writer.md
Name: if_scratch_writer

Overview:
- Producer side of the IF scratchpad circular buffer. The convolution read-side checker consumes this buffer.
- Accepts an input-feature stream over a valid/ready handshake and writes each element into the next scratchpad cell, wrapping modulo CELL_NUMS_IF.
- Publishes the committed write pointer (write_cnt_if), back-pressures when the buffer is full against the reader's oldest live cell, and flags completed rows of if_size elements.

Parameters:
- IF_CELL_SIZE, 8, data width of one IF element.
- IF_ADDRESS_SIZE, 3, scratchpad address width.
- CELL_NUMS_IF, 8, number of scratchpad cells. Must be ≤ 2^IF_ADDRESS_SIZE.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: latch if_size and begin a job.
- if_size  in  3  elements per IF row, valid 1..7.
- in_data  in  IF_CELL_SIZE  input element.
- in_valid  in  1  in_data valid.
- in_last  in  1  qualifies the final element of the job.
- in_ready  out  1  writer can accept a beat this cycle.
- write_start  in  IF_ADDRESS_SIZE  reader's oldest live cell.
- sp_wr_en  out  1  scratchpad write strobe.
- sp_wr_addr  out  IF_ADDRESS_SIZE  scratchpad write address.
- sp_wr_data  out  IF_CELL_SIZE  scratchpad write data.
- write_cnt_if  out  IF_ADDRESS_SIZE  committed write pointer (next cell to be written).
- row_done  out  1  one-cycle pulse when a full row has been committed.
- done  out  1  level: job finished.
- err  out  1  sticky: if_size==0 at start, or in_last ended a partial row.

Behaviour:
- Reset (async, any time, including mid-job): state=IDLE. All outputs are 0 (in_ready, sp_wr_en, sp_wr_addr, sp_wr_data, write_cnt_if, row_done, done, err). Internal wr_ptr=0, col_cnt=0. An in-flight beat is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start with if_size≠0 → RUN; latch if_size; col_cnt=0.
  - start with if_size==0 → err=1, stay IDLE.
- RUN:
  - in_ready = !full, where full = ((wr_ptr+1) mod CELL_NUMS_IF == write_start). One cell is always left empty, so full and empty are never ambiguous.
  - Accept on in_valid && in_ready:
    - wr_ptr ← (wr_ptr+1) mod CELL_NUMS_IF, wrapping from CELL_NUMS_IF-1 to 0 even when CELL_NUMS_IF is not a power of two.
    - col_cnt ← (col_cnt==if_size-1) ? 0 : col_cnt+1.
  - Accepted beat with in_last → DONE.
  - in_last with col_cnt≠if_size-1 also sets err=1.
  - start while in RUN is ignored.
- DONE:
  - done=1 and in_ready=0.
  - start → RUN, clears done/err/col_cnt (same if_size rules as IDLE).
  - wr_ptr and write_cnt_if persist across jobs; only rst clears them.
- Latency, for an accept at edge E:
  - sp_wr_en=1, sp_wr_addr=old wr_ptr, sp_wr_data=in_data are registered and valid in cycle E..E+1.
  - write_cnt_if advances at edge E+1, so the reader never sees a cell counted before it is written.
  - row_done pulses in the same cycle as the sp_wr_en of a beat that completes a row, or of an in_last beat.
- Back-to-back accepts produce a continuous sp_wr_en stream, one write per cycle.
- write_start changing in the same cycle as an accept: full is evaluated combinationally on the current write_start. Freeing a cell can raise in_ready within the same cycle.
- write_start is not checked for consistency. The reader is responsible for never passing write_cnt_if.

Decomposition:
- Shared package (if_sp_pkg):
  - state enum {IDLE, RUN, DONE}.
  - CELL_NUMS_IF / IF_ADDRESS_SIZE defaults.
  - function mod_inc(ptr, n) for circular increment, also used by the read-side checker.
- One sub-module, circ_ptr: modulo-N pointer register with inc enable and async reset. Instantiated twice, for wr_ptr and the committed write_cnt_if.

Test Plan:
- Basic fill: rst, start with if_size=3, 3 beats (0xA1,0xA2,0xA3, last on 3rd), write_start=0 → writes to addrs 0,1,2; write_cnt_if=3 one cycle after each accept; one row_done; done=1; err=0.
- Full stall: write_start=0, stream 10 beats with if_size=7 → in_ready drops after 7 accepts (write_cnt_if=7). Setting write_start=2 → 2 more accepts to addrs 7,0 (wrap), then stall.
- Simultaneous free/accept: wr_ptr=7, write_start=0 (full), raise write_start=1 in the same cycle as in_valid → in_ready=1 that cycle; beat written at addr 7; write_cnt_if=0.
- Partial row: if_size=4, 6 beats with in_last on 6th → row_done pulses after beats 4 and 6; err=1; done=1.
- Reset mid-job: assert rst asynchronously between accepts, mid-cycle → all outputs 0 immediately, state IDLE. A following start with if_size=2 writes from addr 0.
- Restart: after done, start with if_size=2 → done clears next cycle; writes continue from the persisted write_cnt_if (e.g. 3).
